// File: rtl/mul_pkg.sv
// mul_pkg: shared types and elaboration-time helpers for the pipelined
// RISC-V M-extension multiplier (mul_pipe).
//   mul_op_t         - operation encoding presented on in_op
//   op_signed_a/b    - which operands are treated as two's complement
//   rows_after       - row count remaining after a number of 3:2 levels
//   csa_levels       - number of 3:2 levels needed to reach two rows
//   is_boundary      - whether a pipeline register follows a given level
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_t;

  function automatic logic op_signed_a(mul_op_t op);
    return (op == MULH) || (op == MULHSU);
  endfunction

  function automatic logic op_signed_b(mul_op_t op);
    return (op == MULH);
  endfunction

  // Each 3:2 level turns every full group of three rows into two and
  // passes the leftover rows straight through.
  function automatic int rows_after(int rows0, int levels);
    int n;
    n = rows0;
    for (int i = 0; i < levels; i++) begin
      n = (n / 3) * 2 + (n % 3);
    end
    return n;
  endfunction

  // Magnitudes are WIDTH+1 bits wide, so the tree starts with WIDTH+1 rows.
  function automatic int csa_levels(int width);
    int n;
    int cnt;
    n   = width + 1;
    cnt = 0;
    while (n > 2) begin
      n   = (n / 3) * 2 + (n % 3);
      cnt = cnt + 1;
    end
    return cnt;
  endfunction

  // Internal boundary j (1..stages-1) sits after level floor(j*levels/stages),
  // spreading the tree levels as evenly as possible across the stages.
  function automatic logic is_boundary(int pos, int levels, int stages);
    for (int j = 1; j < stages; j++) begin
      if ((j * levels) / stages == pos) return 1'b1;
    end
    return 1'b0;
  endfunction

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_CSA_LEVELS = csa_levels(DEF_WIDTH);

endpackage

// File: rtl/mul_pipe_if.sv
// mul_pipe_if: issue-side and writeback-side handshake of mul_pipe.
//   flush                    - squash everything in flight
//   in_valid/in_ready        - operation handshake (in_op, in_a, in_b, in_tag)
//   out_valid/out_ready      - result handshake (out_data, out_tag)
// master = issue/writeback logic (or bench), slave = the multiplier.
interface mul_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  import mul_pkg::*;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  mul_op_t          in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/csa_3to2.sv
// csa_3to2: one carry-save adder row. Three W-bit rows in, sum and carry out.
// The carry is already shifted left by one, so sum + carry == x + y + z
// (mod 2^W).
//   x, y, z - input rows
//   sum     - bitwise sum
//   carry   - majority bits, pre-shifted into the next weight
module csa_3to2 #(
  parameter int W = 64
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  assign sum      = x ^ y ^ z;
  assign carry[0] = 1'b0;

  for (genvar gi = 1; gi < W; gi++) begin : g_bit
    assign carry[gi] = (x[gi-1] & y[gi-1]) | (x[gi-1] & z[gi-1]) |
                       (y[gi-1] & z[gi-1]);
  end

endmodule

// File: rtl/mul_pipe.sv
// mul_pipe: pipelined MUL/MULH/MULHSU/MULHU for the execute stage.
//   clk, rst  - clock (rising edge), asynchronous active-high reset
//   bus       - mul_pipe_if.slave: valid/ready in, valid/ready out, tag
//               pass-through and flush
// Operands are turned into WIDTH+1 bit magnitudes, the WIDTH+1 partial
// products are reduced by 3:2 levels to two rows, then one carry-propagate
// add, a full-width two's complement fix-up and the half select feed the
// output register. STAGES register boundaries give a latency of STAGES
// advancing cycles at one op per cycle.
module mul_pipe
  import mul_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input logic     clk,
  input logic     rst,
  mul_pipe_if.slave bus
);

  localparam int RW     = 2 * WIDTH;
  localparam int NR     = WIDTH + 1;
  localparam int LEVELS = csa_levels(WIDTH);

  logic             adv;
  logic             accept;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [TAG_W-1:0] out_tag_reg;

  // The whole pipe moves together: it advances whenever the output slot
  // is empty or being drained.
  assign adv          = !out_valid_reg || bus.out_ready;
  assign bus.in_ready = adv && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;

  // Sign conditioning. WIDTH+1 bits keep |most negative| = 2^(WIDTH-1) exact.
  logic           sign_a;
  logic           sign_b;
  logic [WIDTH:0] a_mag;
  logic [WIDTH:0] b_mag;

  assign sign_a = op_signed_a(bus.in_op) && bus.in_a[WIDTH-1];
  assign sign_b = op_signed_b(bus.in_op) && bus.in_b[WIDTH-1];
  assign a_mag  = sign_a ? ({1'b0, ~bus.in_a} + (WIDTH+1)'(1)) : {1'b0, bus.in_a};
  assign b_mag  = sign_b ? ({1'b0, ~bus.in_b} + (WIDTH+1)'(1)) : {1'b0, bus.in_b};

  // lvl[0] holds the partial products; lvl[k] holds the rows after k levels.
  // Rows are 2*WIDTH wide: the true product always fits, so truncation of
  // shifted rows and carries is harmless modulo 2^(2*WIDTH).
  for (genvar gl = 0; gl <= LEVELS; gl++) begin : lvl
    localparam int N = rows_after(NR, gl);

    logic [RW-1:0]    rows [N];
    logic             vld;
    logic             neg;
    mul_op_t          op;
    logic [TAG_W-1:0] tag;

    if (gl == 0) begin : g_src
      for (genvar gi = 0; gi < NR; gi++) begin : g_pp
        assign rows[gi] = b_mag[gi] ? (RW'(a_mag) << gi) : '0;
      end
      assign vld = accept;
      assign neg = sign_a ^ sign_b;
      assign op  = bus.in_op;
      assign tag = bus.in_tag;
    end else begin : g_red
      localparam int NP = rows_after(NR, gl - 1);
      localparam int NG = NP / 3;

      logic [RW-1:0] nxt [N];

      for (genvar gi = 0; gi < NG; gi++) begin : g_csa
        csa_3to2 #(.W(RW)) u_csa (
          .x     (lvl[gl-1].rows[3*gi]),
          .y     (lvl[gl-1].rows[3*gi+1]),
          .z     (lvl[gl-1].rows[3*gi+2]),
          .sum   (nxt[2*gi]),
          .carry (nxt[2*gi+1])
        );
      end

      // Leftover rows (fewer than three) skip this level unchanged.
      for (genvar gi = 2 * NG; gi < N; gi++) begin : g_pass
        assign nxt[gi] = lvl[gl-1].rows[gi+NG];
      end

      if (is_boundary(gl, LEVELS, STAGES)) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            vld <= 1'b0;
          end else if (bus.flush) begin
            vld <= 1'b0;
          end else if (adv) begin
            vld <= lvl[gl-1].vld;
          end
        end

        // Payload needs no reset: it is only looked at alongside vld.
        always_ff @(posedge clk) begin
          if (adv) begin
            rows <= nxt;
            neg  <= lvl[gl-1].neg;
            op   <= lvl[gl-1].op;
            tag  <= lvl[gl-1].tag;
          end
        end
      end else begin : g_comb
        assign rows = nxt;
        assign vld  = lvl[gl-1].vld;
        assign neg  = lvl[gl-1].neg;
        assign op   = lvl[gl-1].op;
        assign tag  = lvl[gl-1].tag;
      end
    end
  end

  // Final CPA, sign fix-up over the full 2*WIDTH bits, then half select.
  logic [RW-1:0]    prod;
  logic [RW-1:0]    result;
  logic [WIDTH-1:0] sel;

  assign prod   = lvl[LEVELS].rows[0] + lvl[LEVELS].rows[1];
  assign result = lvl[LEVELS].neg ? (~prod + RW'(1)) : prod;
  assign sel    = (lvl[LEVELS].op == MUL) ? result[WIDTH-1:0] : result[RW-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_tag_reg   <= '0;
    end else begin
      // Flush empties the output slot even while stalled.
      if (bus.flush) begin
        out_valid_reg <= 1'b0;
      end else if (adv) begin
        out_valid_reg <= lvl[LEVELS].vld;
      end
      if (adv) begin
        out_data_reg <= sel;
        out_tag_reg  <= lvl[LEVELS].tag;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_tag   = out_tag_reg;

endmodule

// File: tb/tb_mul_pipe.sv
// tb_mul_pipe: self-checking bench for mul_pipe (WIDTH=32, STAGES=3).
// Stimulus changes 1 time unit after the rising edge; the monitor samples
// at the falling edge, pushing expected results on accept and popping on
// each completed output handshake.
module tb_mul_pipe;
  import mul_pkg::*;

  localparam int WIDTH  = 32;
  localparam int STAGES = 3;
  localparam int TAG_W  = 5;
  localparam int BOUND  = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mul_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  mul_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   out_count    = 0;

  // Reference: extend operands to 64 bits according to signedness; the low
  // 64 bits of the product are exact under modulo-2^64 multiplication.
  function automatic logic [WIDTH-1:0] ref_mul(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = (op == 2'd1 || op == 2'd2) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (op == 2'd1) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        out_count++;
        tests_run++;
        $display("[TB] result tag=%0d data=%h", bus.out_tag, bus.out_data);
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_result: got tag=%0d data=%h, required no result",
                   bus.out_tag, bus.out_data);
        end else begin
          mon_e = sb.pop_front();
          if (bus.out_data !== mon_e.data || bus.out_tag !== mon_e.tag) begin
            tests_failed++;
            $display("FAIL scoreboard: got tag=%0d data=%h, required tag=%0d data=%h",
                     bus.out_tag, bus.out_data, mon_e.tag, mon_e.data);
          end
        end
      end
      if (bus.flush) sb.delete();
      if (bus.in_valid && bus.in_ready) begin
        mon_e.data = ref_mul(bus.in_op, bus.in_a, bus.in_b);
        mon_e.tag  = bus.in_tag;
        sb.push_back(mon_e);
      end
    end
  end

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // Present one op and hold it until accepted; returns 1 unit after the
  // accepting edge with in_valid still high.
  task automatic drive_op(input mul_op_t op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL accept_timeout: in_ready=0 for %0d cycles, required 1", BOUND);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < BOUND && sb.size() != 0; c++) @(posedge clk);
    @(posedge clk);
    #1;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_%s: %0d results outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    bit bad;
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_op     = MULHU;
    bus.in_a      = 32'h1234_5678;
    bus.in_b      = 32'h9abc_def0;
    bus.in_tag    = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid);
    end
    tests_run++;
    if (bus.out_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_out_data: got %h, required 00000000", bus.out_data);
    end
    tests_run++;
    if (bus.out_tag !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_out_tag: got %0d, required 0", bus.out_tag);
    end
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    idle();
    bad = 1'b0;
    for (int k = 0; k < STAGES + 2; k++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL reset_no_accept: got out_valid=1 after reset, required 0");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_vector(input mul_op_t op, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_d,
                             input string name);
    drive_op(op, a, b, 5'd30);
    idle();
    for (int k = 1; k <= STAGES; k++) begin
      @(negedge clk);
      tests_run++;
      if (bus.out_valid !== (k == STAGES)) begin
        tests_failed++;
        $display("FAIL latency_%s: cycle %0d out_valid=%b, required %b",
                 name, k, bus.out_valid, (k == STAGES));
      end
      if (k == STAGES) begin
        tests_run++;
        if (bus.out_data !== exp_d) begin
          tests_failed++;
          $display("FAIL value_%s: got %h, required %h", name, bus.out_data, exp_d);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int run;
    bus.out_ready = 1'b1;
    run = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          drive_op(mul_op_t'(2'($urandom_range(0, 3))), $urandom(), $urandom(), 5'(i));
        end
        idle();
      end
      begin
        bit started;
        started = 1'b0;
        for (int c = 0; c < BOUND; c++) begin
          @(negedge clk);
          if (bus.out_valid) begin
            started = 1'b1;
            break;
          end
        end
        if (started) begin
          run = 1;
          for (int c = 0; c < BOUND; c++) begin
            @(negedge clk);
            if (!bus.out_valid) break;
            run++;
          end
        end
      end
    join
    tests_run++;
    if (run != 8) begin
      tests_failed++;
      $display("FAIL back_to_back_run: got %0d consecutive results, required 8", run);
    end
    drain("back_to_back");
  endtask

  task automatic test_stall();
    int base;
    bit bad;
    logic [WIDTH-1:0] held_d;
    logic [TAG_W-1:0] held_t;
    base = out_count;
    bus.out_ready = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      drive_op(mul_op_t'(2'($urandom_range(0, 3))), $urandom(), $urandom(), 5'(8 + i));
    end
    bus.in_op  = MULHSU;
    bus.in_a   = $urandom();
    bus.in_b   = $urandom();
    bus.in_tag = 5'd11;
    held_d = bus.out_data;
    held_t = bus.out_tag;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests_run++;
      bad = (bus.in_ready !== 1'b0) || (bus.out_valid !== 1'b1) ||
            (bus.out_data !== held_d) || (bus.out_tag !== held_t);
      if (bad) begin
        tests_failed++;
        $display("FAIL stall_hold: in_ready=%b out_valid=%b data=%h tag=%0d, required 0 1 %h %0d",
                 bus.in_ready, bus.out_valid, bus.out_data, bus.out_tag, held_d, held_t);
      end
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    idle();
    drain("stall");
    tests_run++;
    if (out_count - base != STAGES + 1) begin
      tests_failed++;
      $display("FAIL stall_count: got %0d results, required %0d", out_count - base, STAGES + 1);
    end
  endtask

  task automatic test_flush();
    int base;
    bit bad;
    base = out_count;
    bus.out_ready = 1'b1;
    drive_op(MULH, 32'h8000_0000, 32'h7fff_ffff, 5'd20);
    drive_op(MUL, 32'hdead_beef, 32'h0000_0003, 5'd21);
    bus.flush  = 1'b1;
    bus.in_op  = MULHU;
    bus.in_a   = 32'hffff_0000;
    bus.in_b   = 32'h0001_ffff;
    bus.in_tag = 5'd22;
    @(negedge clk);
    tests_run++;
    if (bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_in_ready: got %b, required 0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    idle();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_out_valid: got %b, required 0", bus.out_valid);
    end
    bad = 1'b0;
    for (int k = 0; k < STAGES + 3; k++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL flush_quiet: got out_valid=1 after flush, required 0");
    end
    @(posedge clk);
    #1;
    test_vector(MULHSU, 32'hffff_fffe, 32'h0000_0010, 32'hffff_ffff, "after_flush");
    tests_run++;
    if (out_count - base != 1) begin
      tests_failed++;
      $display("FAIL flush_count: got %0d results, required 1", out_count - base);
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_op(mul_op_t'(2'($urandom_range(0, 3))), $urandom(), $urandom(), 5'(24 + i));
    end
    idle();
    #2;
    tests_run++;
    if (bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_pre: got out_valid=%b, required 1", bus.out_valid);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_tag !== 5'd0) begin
      tests_failed++;
      $display("FAIL areset_immediate: got valid=%b data=%h tag=%0d, required 0 00000000 0",
               bus.out_valid, bus.out_data, bus.out_tag);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_vector(MULHU, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, "after_reset");
    drain("async_reset");
  endtask

  initial begin
    test_reset();
    test_vector(MUL,    32'hffff_ffff, 32'hffff_ffff, 32'h0000_0001, "mul_m1");
    test_vector(MULH,   32'hffff_ffff, 32'hffff_ffff, 32'h0000_0000, "mulh_m1");
    test_vector(MULHU,  32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, "mulhu_m1");
    test_vector(MULHSU, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff, "mulhsu_m1");
    test_vector(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min_min");
    test_vector(MULH,   32'h8000_0000, 32'h0000_0001, 32'hffff_ffff, "mulh_min_one");
    test_vector(MUL,    32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, "mul_min_m1");
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_pipe.md
Name: mul_pipe

Overview:
- Parametrised, pipelined integer multiplier for the RISC-V M-extension execute stage. Implements MUL, MULH, MULHSU and MULHU.
- Operands are sign-conditioned and partial products are reduced with a 3:2 carry-save tree. A carry-propagate add and exact two's-complement sign fix-up follow.
- The tree is split across STAGES register boundaries, giving one op per cycle throughput.
- Sits between issue and writeback. Valid/ready handshake, tag pass-through and a flush for squashed instructions.

Parameters:
- WIDTH, 32, operand width in bits (even, >= 8).
- STAGES, 3, pipeline depth = accept-to-result latency in cycles (1..4).
- TAG_W, 5, width of the opaque tag (e.g. rd index) carried alongside each op.

Ports:
- clk, input, 1, clock, rising edge.
- rst, input, 1, reset, asynchronous, active-high.
- flush, input, 1, squash all in-flight ops.
- in_valid, input, 1, operation presented.
- in_ready, output, 1, block can accept this cycle.
- in_op, input, 2, mul_op_t: MUL=0, MULH=1, MULHSU=2, MULHU=3.
- in_a, input, WIDTH, rs1 operand.
- in_b, input, WIDTH, rs2 operand.
- in_tag, input, TAG_W, tag returned with the result.
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer accepts result.
- out_data, output, WIDTH, selected product half.
- out_tag, output, TAG_W, tag of the result.

Behaviour:
- Reset (async, rst=1):
  - All stage valid bits clear immediately.
  - out_valid=0, out_data=0, out_tag=0.
  - in_ready follows the advance rule and is 1 while out_valid=0, but nothing is accepted while rst=1.
- Advance rule:
  - adv = !out_valid || out_ready.
  - Every stage register loads only when adv=1; otherwise the whole pipe holds.
  - in_ready = adv && !flush.
  - Accept = in_valid && in_ready.
- Latency and throughput:
  - An op accepted at edge N is presented on out_valid/out_data/out_tag after edge N+STAGES-1, counting only cycles with adv=1.
  - Back-to-back accepts give back-to-back results with no bubbles.
- Stall: while out_valid && !out_ready, out_data and out_tag are held stable and no input is accepted.
- Signedness:
  - a is signed for MULH and MULHSU.
  - b is signed for MULH only.
  - Magnitudes are formed as |x| for signed negative operands. The most negative value maps to 2^(WIDTH-1), so magnitudes are held as WIDTH+1 bits or handled with an unsigned tree plus a correction.
  - neg = sign_a ^ sign_b is carried down the pipe.
  - The 2*WIDTH unsigned product P is computed. The final result is (neg ? ~P+1 : P), the full two's complement over all 2*WIDTH bits. No partial-width sign patching.
- Output select:
  - MUL: out_data = result[WIDTH-1:0].
  - All others: out_data = result[2*WIDTH-1:WIDTH].
  - MUL low half is independent of signedness.
- Partial products: pp[i] = a_mag & {b_mag[i]}, shifted by i. These are reduced by csa_3to2 levels until two rows remain, then a single CPA.
- Stage partition:
  - Register boundaries are placed between tree levels so levels are spread as evenly as possible.
  - The last boundary is the output register (after CPA, sign fix-up and half-select).
  - STAGES=1 means all logic is combinational into the output register.
- Flush:
  - flush=1 clears every stage valid bit, including out_valid, at the next edge regardless of adv.
  - An in_valid in the same cycle is not accepted.
  - Results of flushed ops never appear.
- Simultaneous flush and out_ready: flush wins. The result is still consumed that cycle (the handshake completed), and the pipe is empty after the edge.
- Data registers of invalid stages may hold stale values. out_data is only meaningful with out_valid=1.

Decomposition:
- mul_pkg:
  - typedef enum logic [1:0] mul_op_t {MUL, MULH, MULHSU, MULHU}.
  - Function op_signed_a(op) and op_signed_b(op).
  - localparam for the CSA level count as a function of WIDTH.
- Sub-module csa_3to2: parametrised width, three rows in, sum and carry out. The carry is shifted left one bit inside the sub-module. It is instantiated per tree level via generate.

Test Plan:
- MUL a=0xFFFFFFFF b=0xFFFFFFFF -> out_data=0x00000001. MULH same operands -> 0x00000000. MULHU -> 0xFFFFFFFE. Each appears exactly 3 cycles after accept.
- MULHSU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFF. MULH a=0x80000000 b=0x80000000 -> 0x40000000. MULH a=0x80000000 b=0x00000001 -> 0xFFFFFFFF.
- Stream 8 back-to-back random ops with tags 0..7 and out_ready=1 -> 8 consecutive out_valid cycles. Tags are in order and every data value matches a 64-bit reference model.
- Hold out_ready=0 for 5 cycles with a full pipe -> in_ready=0, out_data/out_tag are stable, and no op is lost or duplicated after release.
- Assert flush with 2 ops in flight and in_valid=1 -> out_valid=0 the next cycle, neither the flushed ops nor the flush-cycle input ever emerge, and the next accepted op returns correctly.
- Assert rst mid-stream asynchronously (off-edge) -> out_valid drops immediately, out_data=0, and after deassert the first accepted op completes with correct latency.
